// File: rtl/maze_pkg.sv
// Shared maze-solver types: move encoding and path-recorder state.
package maze_pkg;
   localparam int MOVE_W = 2;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } move_t;

   typedef enum logic {
      ACTIVE = 1'b0,
      FROZEN = 1'b1
   } stk_state_t;
endpackage

// File: rtl/move_stack.sv
// LIFO recorder of solver moves; freezes on finish and publishes the packed path
// (entry 0 at the LSBs) for the replay queue.
module move_stack
   import maze_pkg::*;
#(
   parameter int DEPTH  = 128,
   parameter int PATH_W = 2 * DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [1:0]        move_in,
   input  logic              finish,
   input  logic              clr,
   output logic [1:0]        top_move,
   output logic              full,
   output logic              empty,
   output logic [7:0]        size,
   output logic [PATH_W-1:0] stack_out,
   output logic              done,
   output logic              ovf,
   output logic              unf
);

   localparam logic [7:0] DEPTH_C = 8'(DEPTH);

   logic [MOVE_W-1:0] entry [DEPTH];
   logic [7:0]        count;
   logic [31:0]       cnt32;
   stk_state_t        state, state_nxt;
   logic              ops_en, do_push, do_repl, do_pop, set_ovf, set_unf;

   assign cnt32 = {24'd0, count};
   assign size  = count;
   assign full  = (count == DEPTH_C);
   assign empty = (count == 8'd0);

   // finish outranks push/pop, so a same-cycle push/pop is dropped
   assign ops_en  = (state == ACTIVE) && !finish && !clr;
   assign do_push = ops_en && push && (!pop || empty) && !full;
   assign do_repl = ops_en && push && pop && !empty;
   assign do_pop  = ops_en && pop && !push && !empty;
   assign set_ovf = ops_en && push && !pop && full;
   assign set_unf = ops_en && pop && !push && empty;

   always_comb begin
      state_nxt = state;
      if (clr)
         state_nxt = ACTIVE;
      else if (state == ACTIVE && finish)
         state_nxt = FROZEN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACTIVE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == ACTIVE) && (state_nxt == FROZEN);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else begin
         if (do_push) count <= count + 8'd1;
         else if (do_pop) count <= count - 8'd1;
         if (set_ovf) ovf <= 1'b1;
         if (set_unf) unf <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            if (do_push && i == cnt32)
               entry[i] <= move_in;
            else if (do_repl && i + 1 == cnt32)
               entry[i] <= move_in;
            else if (do_pop && i + 1 == cnt32)
               entry[i] <= '0;
         end
      end
   end

   always_comb begin
      top_move = '0;
      for (int i = 0; i < DEPTH; i++)
         if (i + 1 == cnt32) top_move = entry[i];
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_pack
      assign stack_out[MOVE_W*g +: MOVE_W] = entry[g];
   end

endmodule

// File: tb/tb_move_stack.sv
// Directed bench for move_stack: queue-based reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_move_stack;
   import maze_pkg::*;

   localparam int DEPTH  = 4;
   localparam int PATH_W = 2 * DEPTH;

   logic              clk = 1'b0;
   logic              rst, push, pop, finish, clr;
   logic [1:0]        move_in;
   logic [1:0]        top_move;
   logic              full, empty, done, ovf, unf;
   logic [7:0]        size;
   logic [PATH_W-1:0] stack_out;

   move_stack #(.DEPTH(DEPTH), .PATH_W(PATH_W)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .move_in(move_in),
      .finish(finish), .clr(clr), .top_move(top_move), .full(full),
      .empty(empty), .size(size), .stack_out(stack_out), .done(done),
      .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit run      = 1'b0;

   // reference model
   logic [1:0] m_q[$];
   bit m_frozen, m_ovf, m_unf, m_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [PATH_W-1:0] m_path();
      logic [PATH_W-1:0] v = '0;
      for (int i = 0; i < m_q.size(); i++) v[2*i +: 2] = m_q[i];
      return v;
   endfunction

   task automatic model_step(input bit r, input bit c, input bit f,
                             input bit pu, input bit po, input logic [1:0] mv);
      if (r || c) begin
         m_q.delete();
         m_frozen = 0; m_ovf = 0; m_unf = 0; m_done = 0;
      end else if (!m_frozen && f) begin
         m_frozen = 1; m_done = 1;
      end else begin
         m_done = 0;
         if (!m_frozen) begin
            if (pu && po) begin
               if (m_q.size() > 0) m_q[m_q.size()-1] = mv;
               else m_q.push_back(mv);
            end else if (pu) begin
               if (m_q.size() == DEPTH) m_ovf = 1;
               else m_q.push_back(mv);
            end else if (po) begin
               if (m_q.size() == 0) m_unf = 1;
               else void'(m_q.pop_back());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("size",      64'(size),      64'(m_q.size()));
         chk("top_move",  64'(top_move),  64'(m_q.size() > 0 ? m_q[m_q.size()-1] : 2'd0));
         chk("empty",     64'(empty),     64'(m_q.size() == 0));
         chk("full",      64'(full),      64'(m_q.size() == DEPTH));
         chk("stack_out", 64'(stack_out), 64'(m_path()));
         chk("done",      64'(done),      64'(m_done));
         chk("ovf",       64'(ovf),       64'(m_ovf));
         chk("unf",       64'(unf),       64'(m_unf));
      end
   end

   task automatic cyc(input bit r, input bit c, input bit f,
                      input bit pu, input bit po, input logic [1:0] mv);
      rst = r; clr = c; finish = f; push = pu; pop = po; move_in = mv;
      @(posedge clk);
      model_step(r, c, f, pu, po, mv);
      @(negedge clk);
   endtask

   task automatic do_push(input logic [1:0] mv); cyc(0, 0, 0, 1, 0, mv); endtask

   initial begin
      rst = 1; clr = 0; finish = 0; push = 0; pop = 0; move_in = '0;
      @(negedge clk);
      run = 1'b1;
      cyc(1, 0, 0, 0, 0, 2'd0);
      chk("rst_size", 64'(size), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);

      // 1: push RIGHT,RIGHT,DOWN
      do_push(RIGHT); do_push(RIGHT); do_push(DOWN);
      chk("t1_size", 64'(size), 64'd3);
      chk("t1_top", 64'(top_move), 64'(DOWN));
      chk("t1_path", 64'(stack_out[5:0]), 64'(6'b10_01_01));
      chk("t1_empty", 64'(empty), 64'd0);

      // 2: pop, then replace top with LEFT
      cyc(0, 0, 0, 0, 1, 2'd0);
      cyc(0, 0, 0, 1, 1, LEFT);
      chk("t2_size", 64'(size), 64'd2);
      chk("t2_top", 64'(top_move), 64'(LEFT));
      chk("t2_path", 64'(stack_out[5:0]), 64'(6'b00_11_01));

      // 3: overflow at DEPTH=4
      cyc(0, 1, 0, 0, 0, 2'd0);
      do_push(RIGHT); do_push(DOWN); do_push(LEFT);
      chk("t3_notfull", 64'(full), 64'd0);
      do_push(RIGHT);
      chk("t3_full", 64'(full), 64'd1);
      do_push(DOWN);
      chk("t3_ovf", 64'(ovf), 64'd1);
      chk("t3_size", 64'(size), 64'd4);
      chk("t3_path", 64'(stack_out), 64'(8'b01_11_10_01));
      cyc(0, 0, 0, 1, 1, UP);
      chk("t3_repl_top", 64'(top_move), 64'(UP));
      chk("t3_ovf_held", 64'(ovf), 64'd1);
      chk("t3_repl_size", 64'(size), 64'd4);

      // 4: underflow, then clr
      cyc(0, 1, 0, 0, 0, 2'd0);
      chk("t4_ovf_clr", 64'(ovf), 64'd0);
      cyc(0, 0, 0, 0, 1, 2'd0);
      chk("t4_unf", 64'(unf), 64'd1);
      chk("t4_size", 64'(size), 64'd0);
      chk("t4_empty", 64'(empty), 64'd1);
      cyc(0, 1, 0, 0, 0, 2'd0);
      chk("t4_unf_clr", 64'(unf), 64'd0);
      // push+pop on empty behaves as push
      cyc(0, 0, 0, 1, 1, DOWN);
      chk("t4_pp_empty_size", 64'(size), 64'd1);
      chk("t4_pp_empty_top", 64'(top_move), 64'(DOWN));
      chk("t4_pp_empty_unf", 64'(unf), 64'd0);
      cyc(0, 1, 0, 0, 0, 2'd0);

      // 5: finish with same-cycle push
      do_push(UP); do_push(LEFT);
      cyc(0, 0, 1, 1, 0, RIGHT);
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_size", 64'(size), 64'd2);
      chk("t5_path", 64'(stack_out[3:0]), 64'(4'b11_00));
      do_push(RIGHT);
      chk("t5_done_off", 64'(done), 64'd0);
      chk("t5_frz_size", 64'(size), 64'd2);
      cyc(0, 0, 0, 0, 1, 2'd0);
      cyc(0, 0, 1, 0, 0, 2'd0);
      chk("t5_no_redone", 64'(done), 64'd0);
      chk("t5_frz_path", 64'(stack_out), 64'(8'b00_00_11_00));
      cyc(0, 0, 0, 1, 0, RIGHT);
      chk("t5_no_ovf", 64'(ovf), 64'd0);
      chk("t5_no_unf", 64'(unf), 64'd0);

      // 6: rst while frozen, then clr mid-ACTIVE
      cyc(1, 0, 0, 0, 0, 2'd0);
      chk("t6_rst_size", 64'(size), 64'd0);
      chk("t6_rst_path", 64'(stack_out), 64'd0);
      chk("t6_rst_done", 64'(done), 64'd0);
      do_push(LEFT); do_push(DOWN); do_push(RIGHT);
      chk("t6_active_size", 64'(size), 64'd3);
      cyc(0, 1, 0, 1, 0, UP);
      chk("t6_clr_size", 64'(size), 64'd0);
      chk("t6_clr_path", 64'(stack_out), 64'd0);
      // ACTIVE again after clr: finish must pulse done
      do_push(LEFT);
      cyc(0, 0, 1, 0, 0, 2'd0);
      chk("t6_refinish_done", 64'(done), 64'd1);
      // clr takes priority over finish
      cyc(0, 1, 1, 0, 0, 2'd0);
      do_push(RIGHT);
      chk("t6_clr_beats_finish", 64'(size), 64'd1);

      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
